if_fetch_buffered: RTL and testbench

Parametrised instruction-fetch stage, successor to the current PC unit.
- Generates PC and drives the instruction SRAM read port (fixed 1-cycle read latency).
- Buffers returned instructions with their PCs in a small FIFO, so decode stalls do not cost a refetch.
- Handles relative, absolute and exception redirects, including squashing of in-flight reads.
- Sits between the instruction SRAM and the ID stage.

---
 rtl/if_fetch_buffered.sv | 85 ++++++++
 tb/tb_if_fetch_buffered.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_buffered.sv
// if_fetch_buffered: PC generation, 1-cycle SRAM fetch and FWFT instruction FIFO with redirect squash
module if_fetch_buffered #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'hbfc00000,
  parameter logic [ADDR_W-1:0] EXC_PC = 32'hbfc00380,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_valid,
  input  logic [1:0]        br_mode,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_offset,
  output logic              inst_sram_en,
  output logic [ADDR_W-1:0] inst_sram_addr,
  input  logic [31:0]       inst_sram_rdata,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [31:0]       id_inst,
  input  logic              id_ready
);
  localparam int PW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0] DEPTH = (CW+1)'(BUF_DEPTH);
  logic [ADDR_W-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d, target;
  logic inflight_q, inflight_d, redir, pop, push;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [ADDR_W-1:0] pc_mem_q [BUF_DEPTH];
  logic [ADDR_W-1:0] pc_mem_d [BUF_DEPTH];
  logic [31:0] inst_mem_q [BUF_DEPTH];
  logic [31:0] inst_mem_d [BUF_DEPTH];

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return p == PW'(BUF_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    redir = br_valid & (br_mode != 2'b00);
    id_valid = ~rst & (count_q != '0) & ~redir;
    pop = id_valid & id_ready;
    push = inflight_q & ~redir;
    // a pop this cycle frees a slot, so the outstanding read always has room when it lands
    inst_sram_en = ~rst & ~redir & ({1'b0, count_q} + (CW+1)'(inflight_q) < DEPTH + (CW+1)'(pop));
    inst_sram_addr = pc_q;
    id_pc = pc_mem_q[rd_ptr_q];
    id_inst = inst_mem_q[rd_ptr_q];
    target = br_mode == 2'b01 ? br_pc + br_offset : br_mode == 2'b10 ? br_offset : EXC_PC;
    pc_d = redir ? target : inst_sram_en ? pc_q + ADDR_W'(4) : pc_q;
    inflight_d = inst_sram_en;
    inflight_pc_d = inst_sram_en ? pc_q : inflight_pc_q;
    pc_mem_d = pc_mem_q;
    inst_mem_d = inst_mem_q;
    if (push) begin
      pc_mem_d[wr_ptr_q] = inflight_pc_q;
      inst_mem_d[wr_ptr_q] = inst_sram_rdata;
    end
    wr_ptr_d = redir ? '0 : push ? wrap_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = redir ? '0 : pop ? wrap_inc(rd_ptr_q) : rd_ptr_q;
    count_d = redir ? '0 : count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
    end else begin
      pc_q <= pc_d;
      inflight_q <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_mem_q <= pc_mem_d;
    inst_mem_q <= inst_mem_d;
  end
endmodule

// File: tb/tb_if_fetch_buffered.sv
// tb_if_fetch_buffered: directed scenario tests for the buffered fetch stage
module tb_if_fetch_buffered;
  logic clk = 1'b0, rst = 1'b1, br_valid = 1'b0, id_ready = 1'b0;
  logic [1:0] br_mode = 2'b00;
  logic [31:0] br_pc = '0, br_offset = '0, inst_sram_rdata = '0;
  logic inst_sram_en, id_valid;
  logic [31:0] inst_sram_addr, id_pc, id_inst;
  int errors = 0, checks = 0;
  localparam logic [31:0] RST_PC = 32'hbfc00000;

  if_fetch_buffered dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_mode(br_mode), .br_pc(br_pc),
    .br_offset(br_offset), .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata), .id_valid(id_valid), .id_pc(id_pc),
    .id_inst(id_inst), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [31:0] a);
    return a ^ 32'h13579bdf;
  endfunction

  // SRAM model: one-cycle read latency, garbage when not requested
  always @(posedge clk) inst_sram_rdata <= inst_sram_en ? mk(inst_sram_addr) : 32'hdeadbeef;

  task automatic chk_en(input string n, input logic exp);
    checks++;
    if (inst_sram_en !== exp) begin errors++; $display("FAIL %s en got %b want %b", n, inst_sram_en, exp); end
  endtask

  task automatic chk_addr(input string n, input logic [31:0] exp);
    checks++;
    if (inst_sram_en !== 1'b1 || inst_sram_addr !== exp) begin
      errors++; $display("FAIL %s req got en=%b addr=%h want addr=%h", n, inst_sram_en, inst_sram_addr, exp);
    end
  endtask

  task automatic chk_iv(input string n, input logic exp);
    checks++;
    if (id_valid !== exp) begin errors++; $display("FAIL %s id_valid got %b want %b", n, id_valid, exp); end
  endtask

  task automatic chk_head(input string n, input logic [31:0] exp_pc);
    checks++;
    if (id_valid !== 1'b1 || id_pc !== exp_pc || id_inst !== mk(exp_pc)) begin
      errors++; $display("FAIL %s head got v=%b pc=%h inst=%h want pc=%h inst=%h", n, id_valid, id_pc, id_inst, exp_pc, mk(exp_pc));
    end
  endtask

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rst = 1'b1; br_valid = 1'b0; br_mode = 2'b00; id_ready = rdy;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; id_ready = 1'b1;
    #1;
    chk_en("reset_en", 1'b0);
    chk_iv("reset_iv", 1'b0);
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      chk_addr("stream_addr", RST_PC + 32'(4 * k));
      if (k < 2) chk_iv("stream_iv", 1'b0);
      else chk_head("stream_head", RST_PC + 32'(4 * (k - 2)));
    end
  endtask

  task automatic test_stall();
    do_reset(1'b1);
    @(negedge clk); #1;
    @(negedge clk); id_ready = 1'b0; #1;
    chk_en("stall_en_t2", 1'b0);
    chk_head("stall_head_t2", RST_PC);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk_en("stall_en_hold", 1'b0);
      chk_head("stall_head_hold", RST_PC);
    end
    @(negedge clk); id_ready = 1'b1; #1;
    chk_addr("resume_addr0", RST_PC + 32'h8);
    chk_head("resume_head0", RST_PC);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); #1;
      chk_addr("resume_addr", RST_PC + 32'(8 + 4 * k));
      chk_head("resume_head", RST_PC + 32'(4 * k));
    end
  endtask

  task automatic test_redirect_rel();
    do_reset(1'b1);
    @(negedge clk); #1;
    @(negedge clk);
    br_valid = 1'b1; br_mode = 2'b01; br_pc = 32'hbfc00008; br_offset = 32'h10;
    #1;
    chk_en("rel_redir_en", 1'b0);
    chk_iv("rel_redir_iv", 1'b0);
    @(negedge clk); br_valid = 1'b0; #1;
    chk_addr("rel_target", 32'hbfc00018);
    chk_iv("rel_flushed", 1'b0);
    @(negedge clk); #1;
    chk_addr("rel_next", 32'hbfc0001c);
    chk_iv("rel_dropped", 1'b0);
    @(negedge clk); #1;
    chk_head("rel_head", 32'hbfc00018);
  endtask

  task automatic test_exc_full();
    do_reset(1'b0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk_en("exc_fill_en", 1'b0);
    @(negedge clk); #1;
    chk_head("exc_full_head", RST_PC);
    @(negedge clk); br_valid = 1'b1; br_mode = 2'b11; #1;
    chk_en("exc_redir_en", 1'b0);
    chk_iv("exc_redir_iv", 1'b0);
    @(negedge clk); br_valid = 1'b0; #1;
    chk_addr("exc_target", 32'hbfc00380);
    chk_iv("exc_flushed", 1'b0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk_head("exc_head", 32'hbfc00380);
  endtask

  task automatic test_abs();
    do_reset(1'b1);
    @(negedge clk); #1;
    @(negedge clk);
    br_valid = 1'b1; br_mode = 2'b10; br_offset = 32'h80001000; br_pc = 32'h12345678;
    #1;
    chk_iv("abs_redir_iv", 1'b0);
    @(negedge clk); br_valid = 1'b0; #1;
    chk_addr("abs_target", 32'h80001000);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk_head("abs_head", 32'h80001000);
  endtask

  task automatic test_wrap_mode0();
    do_reset(1'b1);
    br_valid = 1'b1; br_mode = 2'b10; br_offset = 32'hfffffffc;
    #1;
    chk_en("wrap_redir_en", 1'b0);
    @(negedge clk); br_valid = 1'b0; #1;
    chk_addr("wrap_top", 32'hfffffffc);
    @(negedge clk); #1;
    chk_addr("wrap_zero", 32'h0);
    @(negedge clk); br_valid = 1'b1; br_mode = 2'b00; br_offset = 32'h40; #1;
    chk_addr("mode0_ignored", 32'h4);
    chk_head("mode0_head", 32'hfffffffc);
    @(negedge clk); br_valid = 1'b0; #1;
    chk_addr("mode0_next", 32'h8);
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    br_valid = 1'b1; br_mode = 2'b10; br_offset = 32'h00002000;
    @(negedge clk); br_mode = 2'b01; br_pc = 32'h00003000; br_offset = 32'h20; #1;
    chk_en("b2b_no_issue", 1'b0);
    @(negedge clk); br_valid = 1'b0; #1;
    chk_addr("b2b_last_wins", 32'h00003020);
  endtask

  task automatic test_rst_mid();
    do_reset(1'b1);
    for (int k = 0; k < 3; k++) begin @(negedge clk); #1; end
    @(negedge clk); rst = 1'b1; #1;
    chk_en("rstmid_en", 1'b0);
    chk_iv("rstmid_iv", 1'b0);
    @(negedge clk); rst = 1'b0; #1;
    chk_addr("rstmid_restart", RST_PC);
    chk_iv("rstmid_iv0", 1'b0);
    @(negedge clk); #1;
    chk_addr("rstmid_addr1", RST_PC + 32'h4);
    chk_iv("rstmid_stale_dropped", 1'b0);
    @(negedge clk); #1;
    chk_head("rstmid_head", RST_PC);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_rel();
    test_exc_full();
    test_abs();
    test_wrap_mode0();
    test_back_to_back();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
